// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-fetch controller: FETCH over req/ack, then one EXEC slot per instruction.
// Define PC_MISALIGN_TRAP_EN to add the TRAP state and the misalign output.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        is_branch,
   input  logic        br_taken,
   input  logic        jump,
   input  logic [31:0] target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1
`ifdef PC_MISALIGN_TRAP_EN
      ,
      TRAP  = 2'd2
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   logic        instr_valid_q;
   logic        redirect;
   logic [31:0] target_aligned;
   logic [31:0] pc_plus4_w;

   assign redirect   = jump | (is_branch & br_taken);
   assign pc_plus4_w = pc_q + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
   logic misalign_q;
   logic misaligned_target;
   logic unused_target_lsb;

   assign target_aligned    = {target[31:1], 1'b0};
   assign misaligned_target = redirect & target[1];
   assign unused_target_lsb = target[0];
`else
   logic unused_cfg_bits;

   // Without the trap, misaligned targets are silently word-aligned.
   assign target_aligned  = {target[31:2], 2'b00};
   assign unused_cfg_bits = ^{target[1:0], TRAP_VEC};
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         instr_q       <= NOP;
         retired_q     <= 32'd0;
         instr_valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         retired_q     <= retired_d;
         instr_valid_q <= (state_d == EXEC);
`ifdef PC_MISALIGN_TRAP_EN
         misalign_q    <= (state_d == TRAP);
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: begin
            if (imem_ack) state_d = EXEC;
         end
         EXEC: begin
            if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
               state_d = misaligned_target ? TRAP : FETCH;
`else
               state_d = FETCH;
`endif
            end
         end
`ifdef PC_MISALIGN_TRAP_EN
         TRAP: state_d = FETCH;
`endif
         default: state_d = FETCH;
      endcase
   end

   // Datapath next values; an instruction retires only on a clean EXEC -> FETCH edge.
   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      if (state_q == FETCH && imem_ack) begin
         instr_d = imem_rdata;
      end
      if (state_q == EXEC && state_d == FETCH) begin
         retired_d = retired_q + 32'd1;
         pc_d      = redirect ? target_aligned : pc_plus4_w;
      end
`ifdef PC_MISALIGN_TRAP_EN
      if (state_q == TRAP) begin
         pc_d = TRAP_VEC;
      end
`endif
   end

   // Outputs
   always_comb begin
      imem_req    = (state_q == FETCH) & rst_n;
      imem_addr   = pc_q;
      instr       = instr_q;
      instr_valid = instr_valid_q;
      pc          = pc_q;
      pc_plus4    = pc_plus4_w;
      retired     = retired_q;
`ifdef PC_MISALIGN_TRAP_EN
      misalign    = misalign_q;
`endif
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table of redirect cases plus hand-written
// sequences for wait states, stall, misaligned target and reset mid-fetch.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        is_branch = 1'b0, br_taken = 1'b0, jump = 1'b0, stall = 1'b0;
   logic [31:0] target = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instr, pc, pc_plus4, retired;
   logic        instr_valid;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   pc_fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
      .clk(clk), .rst_n(rst_n),
      .is_branch(is_branch), .br_taken(br_taken), .jump(jump), .target(target), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
`ifdef PC_MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] setup_pc;
      logic        isb;
      logic        brt;
      logic        jmp;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
   } vec_t;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] pc_m;
   logic [31:0] word_m;
   logic [31:0] ret_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge while in FETCH; leaves the DUT in EXEC at a negedge.
   task automatic fetch_phase(input logic [31:0] word, input int waits);
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         pc_m = pc;
      end else begin
         pc_m = exp_q.pop_front();
      end
      word_m = word;
      for (int i = 0; i <= waits; i++) begin
         chk("fetch_req", {31'd0, imem_req}, 32'd1);
         chk("fetch_addr", imem_addr, pc_m);
         chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
         if (i == waits) begin
            imem_ack   = 1'b1;
            imem_rdata = word;
         end
         @(negedge clk);
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
      end
      chk("exec_valid", {31'd0, instr_valid}, 32'd1);
      chk("exec_instr", instr, word_m);
      chk("exec_pc", pc, pc_m);
      chk("exec_pc_plus4", pc_plus4, pc_m + 32'd4);
      $display("fetch pc=%h word=%h waits=%0d", pc_m, word, waits);
   endtask

   task automatic exec_phase(input int stall_n, input logic isb, input logic brt, input logic jmp,
                             input logic [31:0] tgt, input logic [31:0] exp_next, input bit trap);
      for (int i = 0; i < stall_n; i++) begin
         stall = 1'b1;
         @(negedge clk);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_instr", instr, word_m);
         chk("stall_pc", pc, pc_m);
         chk("stall_retired", retired, ret_m);
      end
      stall     = 1'b0;
      is_branch = isb;
      br_taken  = brt;
      jump      = jmp;
      target    = tgt;
      exp_q.push_back(exp_next);
      @(negedge clk);
      is_branch = 1'b0;
      br_taken  = 1'b0;
      jump      = 1'b0;
      target    = $urandom;
      if (trap) begin
`ifdef PC_MISALIGN_TRAP_EN
         chk("trap_misalign", {31'd0, misalign}, 32'd1);
`endif
         chk("trap_valid", {31'd0, instr_valid}, 32'd0);
         chk("trap_req", {31'd0, imem_req}, 32'd0);
         chk("trap_retired", retired, ret_m);
         @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
         chk("trap_pulse_end", {31'd0, misalign}, 32'd0);
`endif
      end else begin
         ret_m = ret_m + 32'd1;
         chk("exec_retired", retired, ret_m);
      end
      $display("exec pc=%h br=%0b tk=%0b j=%0b tgt=%h next=%h stalls=%0d", pc_m, isb, brt, jmp, tgt,
               exp_next, stall_n);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h10, 1'b1, 1'b1, 1'b0, 32'h40, 32'h40};
      vecs[1] = '{32'h10, 1'b1, 1'b0, 1'b0, 32'h40, 32'h14};
      vecs[2] = '{32'h10, 1'b0, 1'b1, 1'b0, 32'h40, 32'h14};
      vecs[3] = '{32'h20, 1'b0, 1'b0, 1'b1, 32'h81, 32'h80};
      vecs[4] = '{32'h20, 1'b1, 1'b0, 1'b1, 32'h200, 32'h200};
      vecs[5] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0};
      vecs[6] = '{32'h30, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
      ret_m = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_retired", retired, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
      rst_n = 1'b1;
      exp_q.push_back(RESET_PC);
      @(negedge clk);

      // Straight-line fetch
      for (int i = 0; i < 3; i++) begin
         fetch_phase($urandom, 0);
         exec_phase(0, 1'b0, 1'b0, 1'b0, 32'h0, pc_m + 32'd4, 1'b0);
      end
      chk("retired_after_3", retired, 32'd3);

      // Wait states then stall
      fetch_phase(32'hCAFE_0013, 3);
      exec_phase(2, 1'b0, 1'b0, 1'b0, 32'h0, pc_m + 32'd4, 1'b0);

      // Redirect vector table: first jump to the setup PC, then apply the vector
      foreach (vecs[k]) begin
         fetch_phase($urandom, 0);
         exec_phase(0, 1'b0, 1'b0, 1'b1, vecs[k].setup_pc, vecs[k].setup_pc, 1'b0);
         fetch_phase($urandom, k % 2);
         exec_phase(0, vecs[k].isb, vecs[k].brt, vecs[k].jmp, vecs[k].tgt, vecs[k].exp_pc, 1'b0);
      end

      // Misaligned jump target
      fetch_phase($urandom, 0);
`ifdef PC_MISALIGN_TRAP_EN
      exec_phase(0, 1'b0, 1'b0, 1'b1, 32'h42, TRAP_VEC, 1'b1);
`else
      exec_phase(0, 1'b0, 1'b0, 1'b1, 32'h42, 32'h40, 1'b0);
`endif
      fetch_phase($urandom, 0);
      exec_phase(0, 1'b0, 1'b0, 1'b0, 32'h0, pc_m + 32'd4, 1'b0);

      // Reset asserted mid-FETCH with an ack arriving during reset
      chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_req", {31'd0, imem_req}, 32'd0);
      chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("mid_rst_pc", pc, RESET_PC);
      chk("mid_rst_instr", instr, 32'h0000_0013);
      chk("mid_rst_retired", retired, 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      ret_m = 32'd0;
      @(negedge clk);
      fetch_phase($urandom, 1);
      exec_phase(0, 1'b0, 1'b0, 1'b0, 32'h0, pc_m + 32'd4, 1'b0);
      fetch_phase($urandom, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
